// File: rtl/prefetch_pkg.sv
// Shared types and sizing helpers for the instruction prefetch queue.
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUS_WAIT = 2'd1,
    DISCARD  = 2'd2
  } state_e;

  localparam int DEPTH_DEFAULT  = 6;
  localparam int ADDR_W_DEFAULT = 16;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/prefetch_queue_byte_fifo.sv
// Circular byte buffer with push/pop/clear; clear has priority over push and pop.
module byte_fifo
  import prefetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [7:0]       wdata,
  input  logic             pop,
  output logic [7:0]       rdata,
  output logic [CNT_W-1:0] count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       mem_q [DEPTH];
  logic [IDX_W-1:0] rd_q, rd_d;
  logic [IDX_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = idx_inc(wr_q);
      if (pop)  rd_d = idx_inc(rd_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !clear) begin
      mem_q[wr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: runs a fetch pointer ahead of the execution IP
// and buffers returned bytes for the decoder.
//   state    | meaning
//   IDLE     | no request outstanding; issue one if a slot is free
//   BUS_WAIT | request outstanding, returned byte will be queued
//   DISCARD  | request outstanding across a flush, returned byte is dropped
module prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              q_valid,
  output logic [7:0]        q_byte,
  output logic [ADDR_W-1:0] q_ip,
  input  logic              q_pop,
  output logic [3:0]        q_count
);

  localparam int CNT_W = cnt_w(DEPTH);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fetch_q, fetch_d;
  logic [ADDR_W-1:0] ip_q, ip_d;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_push, fifo_pop;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    fetch_d   = fetch_q;
    ip_d      = ip_q;
    fifo_push = 1'b0;
    fifo_pop  = q_pop && q_valid && !flush;

    if (fifo_pop) ip_d = ip_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        if (!flush && (fifo_count < CNT_W'(DEPTH))) begin
          req_d   = 1'b1;
          addr_d  = fetch_q;
          state_d = BUS_WAIT;
        end
      end
      BUS_WAIT: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (!flush) begin
            fifo_push = 1'b1;
            fetch_d   = fetch_q + ADDR_W'(1);
          end
        end else if (flush) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Flush overrides any pointer update from the same cycle.
    if (flush) begin
      fetch_d = flush_addr;
      ip_d    = flush_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      fetch_q <= '0;
      ip_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      fetch_q <= fetch_d;
      ip_q    <= ip_d;
    end
  end

  byte_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (flush),
    .push   (fifo_push),
    .wdata  (mem_rdata),
    .pop    (fifo_pop),
    .rdata  (q_byte),
    .count  (fifo_count)
  );

  assign mem_req  = req_q;
  assign mem_addr = addr_q;
  assign q_ip     = ip_q;
  assign q_valid  = (fifo_count != '0);
  assign q_count  = 4'(fifo_count);

endmodule
